gray_wr_ptr_ctrl: RTL and testbench
===================================

# gray_wr_ptr_ctrl

Write-side pointer controller for the dual-clock FIFO. It keeps the binary write pointer and drives the RAM write port, and it publishes a registered Gray-coded copy of the pointer for the read domain. It also resynchronises the read domain's Gray pointer, converts it back to binary, and produces full, fill level and overflow status. It is the binary-to-Gray (transmit) counterpart of the read-side Gray decode path, and sits between the FIFO write interface and the dual-port RAM.

## Interface
Parameters:
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2^ADDR_WIDTH; legal range 2..12; pointers are ADDR_WIDTH+1 bits

Ports:
- i_clk  input  1  write-domain clock; all logic is on the rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_wr_en  input  1  write request
- i_rd_gray_ptr  input  ADDR_WIDTH+1  read pointer, Gray-coded, from the read clock domain (asynchronous to i_clk)
- o_ram_wen  output  1  RAM write enable
- o_ram_waddr  output  ADDR_WIDTH  RAM write address
- o_wr_gray_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain
- o_full  output  1  FIFO full, registered
- o_wr_level  output  ADDR_WIDTH+1  fill level seen from the write side, registered, range 0..2^ADDR_WIDTH
- o_wr_err  output  1  one-cycle overflow pulse

## Operation
- Internal state:
  - wr_bin: binary write pointer, ADDR_WIDTH+1 bits.
  - rq1, rq2: two-flop synchroniser for i_rd_gray_ptr.
- Reset values: wr_bin, rq1, rq2, o_wr_gray_ptr, o_full, o_wr_level and o_wr_err are all 0.
- accept = i_wr_en & ~o_full.
- wr_bin_next = wr_bin + accept, modulo 2^(ADDR_WIDTH+1). Wrap from all-ones to 0 is natural; no saturation.
- Combinational outputs:
  - o_ram_wen = accept.
  - o_ram_waddr = wr_bin[ADDR_WIDTH-1:0].
  - The RAM write therefore occurs in the same cycle as the request.
- Binary-to-Gray conversion: g = b ^ (b >> 1).
  - o_wr_gray_ptr <= gray(wr_bin_next) on every edge.
  - Invariant: o_wr_gray_ptr == gray(wr_bin) at all times after reset.
  - Only one bit of o_wr_gray_ptr changes per accepted write. This is what makes the CDC safe.
- Synchroniser: rq1 <= i_rd_gray_ptr, then rq2 <= rq1. No logic is placed between the two stages.
- Gray-to-binary conversion of rq2: rd_bin[MSB] = rq2[MSB]; each lower bit rd_bin[k] = rq2[k] ^ rd_bin[k+1].
- Full is registered:
  - o_full <= (gray(wr_bin_next) == {~rq2[A:A-1], rq2[A-2:0]}), where A = ADDR_WIDTH.
  - In words: both top Gray bits are inverted and all other bits are equal.
- Level: o_wr_level <= wr_bin_next − rd_bin, modulo 2^(ADDR_WIDTH+1).
- Overflow: o_wr_err <= i_wr_en & o_full.
  - A write presented while full is dropped: no RAM write and no pointer change.
  - It is not queued.
- Full and level are pessimistic: a read-side advance reaches them late, never early. The FIFO never reports not-full while actually full.
- Reset mid-operation: all state returns to reset values asynchronously, regardless of i_wr_en. The first write after reset release goes to address 0.

## Timing
- Write accepted at edge N:
  - RAM write occurs at edge N.
  - o_wr_gray_ptr, o_full and o_wr_level reflect it after edge N (zero extra latency).
- Read-pointer change on i_rd_gray_ptr, stable before edge M:
  - rq2 updates at edge M+1.
  - o_full and o_wr_level update at edge M+2.
  - o_full deasserts at most 3 cycles after the read-side change.
- Writing on the cycle o_full asserts: the write is refused in that same cycle (o_full is already high), and o_wr_err pulses in the next cycle.
- Back-to-back writes: one per clock while not full; no bubbles.
- Simultaneous write and read-pointer change: write-side accounting applies first. o_wr_level reflects the new rq2 two edges later.

## Test plan
- Reset:
  - Stimulus: assert i_rst with i_wr_en=1, read pointer at 0.
  - Required: all outputs 0, o_ram_wen=0; after release, the first write uses o_ram_waddr=0.
- Fill to full (ADDR_WIDTH=4, i_rd_gray_ptr=0):
  - Stimulus: 16 consecutive writes.
  - Required: o_ram_waddr runs 0..15; after the 16th write, o_full=1, o_wr_level=16, o_wr_gray_ptr=5'b11000.
- Overflow:
  - Stimulus: assert i_wr_en for 2 cycles while full.
  - Required: o_ram_wen stays 0, pointer unchanged, o_wr_err high for 2 cycles, each 1 cycle late.
- Drain release:
  - Stimulus: set i_rd_gray_ptr = 5'b00110 (binary 4).
  - Required: o_full=0 and o_wr_level=12 exactly 2 edges after the first sampling edge; next write goes to address 0.
- Wrap-around:
  - Stimulus: continuous writes, with the read pointer tracking 4 behind.
  - Required: the pointer passes binary 31 → 0 (Gray 10000 → 00000); every step changes exactly one Gray bit; o_full never asserts.
- Gray invariant:
  - Stimulus: randomized i_wr_en and legal Gray read-pointer sequences for 10k cycles.
  - Required: o_wr_gray_ptr == gray(wr_bin) and Hamming distance ≤ 1 per cycle.
  - Required: o_wr_level ≤ 16, and o_full=1 exactly when o_wr_level=16.

Source files
------------

// File: rtl/gray_wr_ptr_ctrl.sv
// gray_wr_ptr_ctrl
// Write-side pointer controller for a dual-clock FIFO. It owns the binary
// write pointer and drives the RAM write port. It publishes a registered
// Gray copy of the pointer to the read domain. It also resynchronises the
// read domain's Gray pointer to produce full, fill level and overflow status.
//
// Write handshake: i_wr_en is a request and ~o_full is the ready. A write is
// accepted (o_ram_wen) in any cycle where the request is high, the FIFO is not
// full and reset is low. A request made while full is dropped, not held over,
// and o_wr_err flags it one cycle later.
module gray_wr_ptr_ctrl #(
    parameter int ADDR_WIDTH = 4           // legal range 2..12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH:0]   i_rd_gray_ptr,
    output logic                  o_ram_wen,
    output logic [ADDR_WIDTH-1:0] o_ram_waddr,
    output logic [ADDR_WIDTH:0]   o_wr_gray_ptr,
    output logic                  o_full,
    output logic [ADDR_WIDTH:0]   o_wr_level,
    output logic                  o_wr_err
);

    localparam int PW = ADDR_WIDTH + 1;

    typedef logic [PW-1:0] ptr_t;

    // Binary to Gray: adjacent counts differ in exactly one bit.
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Write pointer state
    ptr_t wr_bin_q;
    ptr_t wr_bin_d;
    ptr_t wr_gray_q;
    ptr_t wr_gray_d;

    // Read pointer synchroniser stages (Gray coded)
    ptr_t rq1_q;
    ptr_t rq2_q;

    // Status registers
    logic full_q;
    logic full_d;
    ptr_t level_q;
    ptr_t level_d;
    logic err_q;
    logic err_d;

    // Combinational helpers
    logic accept;
    ptr_t rd_bin;
    ptr_t full_gray;

    // Accept a write only when there is room. Holding reset also blocks the RAM
    // write, so the write port stays quiet during reset whatever i_wr_en does.
    always_comb begin
        accept    = i_wr_en & ~full_q & ~i_rst;
        wr_bin_d  = wr_bin_q + {{ADDR_WIDTH{1'b0}}, accept};
        wr_gray_d = bin2gray(wr_bin_d);
    end

    // Decode the synchronised Gray read pointer back to binary, MSB downward.
    always_comb begin
        rd_bin         = '0;
        rd_bin[PW-1]   = rq2_q[PW-1];
        for (int k = PW - 2; k >= 0; k--) begin
            rd_bin[k] = rq2_q[k] ^ rd_bin[k+1];
        end
    end

    // Next-state status. Full is detected in the Gray domain: the write pointer
    // is one whole lap ahead of the read pointer when the top two Gray bits are
    // inverted and the rest match. The level uses the stale (synchronised) read
    // pointer, so it can only overstate occupancy, never understate it.
    always_comb begin
        full_gray = {~rq2_q[PW-1:PW-2], rq2_q[PW-3:0]};
        full_d    = (wr_gray_d == full_gray);
        level_d   = wr_bin_d - rd_bin;
        err_d     = i_wr_en & full_q;
    end

    // Write pointer and its published Gray copy advance together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
        end
    end

    // Two-flop synchroniser for the asynchronous read pointer. There is no
    // logic between the stages.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rq1_q <= '0;
            rq2_q <= '0;
        end else begin
            rq1_q <= i_rd_gray_ptr;
            rq2_q <= rq1_q;
        end
    end

    // Registered full, level and overflow pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full_q  <= 1'b0;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Output wiring: the RAM write happens in the same cycle as the request.
    always_comb begin
        o_ram_wen     = accept;
        o_ram_waddr   = wr_bin_q[ADDR_WIDTH-1:0];
        o_wr_gray_ptr = wr_gray_q;
        o_full        = full_q;
        o_wr_level    = level_q;
        o_wr_err      = err_q;
    end

endmodule

// File: tb/tb_gray_wr_ptr_ctrl.sv
// Bench for gray_wr_ptr_ctrl with ADDR_WIDTH = 4.
// The reference model counts writes and reads as plain integers. It derives
// occupancy as their difference, delayed by the two-edge view of the read side.
module tb_gray_wr_ptr_ctrl;

  localparam int A     = 4;
  localparam int DEPTH = 1 << A;
  localparam int LAP   = 2 * DEPTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [A:0]   rd_gray = '0;
  logic         ram_wen;
  logic [A-1:0] ram_waddr;
  logic [A:0]   wr_gray;
  logic         full;
  logic [A:0]   wr_level;
  logic         wr_err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // reference model state
  int   wr_abs;       // writes accepted since reset (unwrapped)
  int   rd_abs;       // reads performed by the read side (unwrapped)
  int   m_q1, m_q2;   // read count as seen 1 / 2 edges later (mod LAP)
  int   m_level;
  logic m_full;
  logic m_err;
  logic [A:0] prev_gray;
  logic saw_wrap;

  gray_wr_ptr_ctrl #(.ADDR_WIDTH(A)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_en       (wr_en),
    .i_rd_gray_ptr (rd_gray),
    .o_ram_wen     (ram_wen),
    .o_ram_waddr   (ram_waddr),
    .o_wr_gray_ptr (wr_gray),
    .o_full        (full),
    .o_wr_level    (wr_level),
    .o_wr_err      (wr_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [A:0] to_gray(input int n);
    logic [A:0] b;
    b = n[A:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wr_abs    = 0;
    rd_abs    = 0;
    m_q1      = 0;
    m_q2      = 0;
    m_level   = 0;
    m_full    = 1'b0;
    m_err     = 1'b0;
    prev_gray = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"},   ram_wen,   0);
    check({tag, "_waddr"}, ram_waddr, 0);
    check({tag, "_gray"},  wr_gray,   0);
    check({tag, "_full"},  full,      0);
    check({tag, "_level"}, wr_level,  0);
    check({tag, "_err"},   wr_err,    0);
  endtask

  // reset with a write request held high; outputs must stay at zero
  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    wr_en   = 1'b1;
    rd_gray = '0;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("rst_held");
    rst   = 1'b0;
    wr_en = 1'b0;
    model_reset();
  endtask

  // driver: one clock with the given request and read count; checks every output
  task automatic step(input logic en, input int rd_count);
    logic m_acc;
    logic old_full;
    int   m_wr;
    @(negedge clk);
    wr_en   = en;
    rd_gray = to_gray(rd_count % LAP);
    #1;
    m_wr  = wr_abs % LAP;
    m_acc = en && !m_full;
    check("ram_wen",   ram_wen,   m_acc);
    check("ram_waddr", ram_waddr, m_wr % DEPTH);
    check("wr_gray",   wr_gray,   to_gray(m_wr));
    check("full",      full,      m_full);
    check("level",     wr_level,  m_level);
    check("wr_err",    wr_err,    m_err);
    check("gray_hamming_le1", ($countones(wr_gray ^ prev_gray) <= 1), 1);
    check("level_le_depth", (wr_level <= DEPTH), 1);
    check("full_iff_level_depth", full, (wr_level == DEPTH));
    prev_gray = wr_gray;
    @(posedge clk);
    // model update at this edge
    old_full = m_full;
    if (m_acc) begin
      if (m_wr == LAP - 1) saw_wrap = 1'b1;
      wr_abs++;
    end
    m_level = ((wr_abs % LAP) - m_q2 + LAP) % LAP;
    m_full  = (m_level == DEPTH);
    m_err   = en && old_full;
    m_q2    = m_q1;
    m_q1    = rd_count % LAP;
  endtask

  initial begin
    saw_wrap = 1'b0;
    model_reset();

    // 1. reset, then first write goes to address 0
    apply_reset();
    @(negedge clk);
    wr_en = 1'b1;
    #1;
    check("first_write_wen",  ram_wen,   1);
    check("first_write_addr", ram_waddr, 0);
    wr_en = 1'b0;

    // 2. fill to full with the read pointer parked at 0
    for (int i = 0; i < DEPTH; i++) step(1'b1, 0);
    #1;
    check("fill_full",  full,     1);
    check("fill_level", wr_level, DEPTH);
    check("fill_gray",  wr_gray,  5'b11000);

    // 3. overflow: two refused writes, error pulses one cycle late
    step(1'b1, 0);
    step(1'b1, 0);
    #1;
    check("ovf_gray_unchanged", wr_gray, 5'b11000);
    check("ovf_err_late",       wr_err,  1);

    // 4. drain release: read side reports 4 reads (Gray 00110)
    rd_abs = 4;
    step(1'b0, rd_abs);
    #1;
    check("drain_full_edge1", full, 1);
    step(1'b0, rd_abs);
    #1;
    check("drain_full_edge2", full, 1);
    step(1'b0, rd_abs);
    #1;
    check("drain_full_edge3", full,     0);
    check("drain_level",      wr_level, 12);
    step(1'b1, rd_abs);  // write goes to address 0 (checked by the model)

    // 5. wrap-around: continuous writes, reads trailing 4 behind
    for (int i = 0; i < 40; i++) begin
      rd_abs = wr_abs - 4;
      step(1'b1, rd_abs);
      check("wrap_never_full", full, 0);
    end
    check("wrap_seen", saw_wrap, 1);

    // 6. randomized traffic, with one reset part-way through
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        apply_reset();
      end
      if (rd_abs < wr_abs && $urandom_range(0, 3) != 0) rd_abs++;
      step(1'($urandom_range(0, 1)), rd_abs);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
